memtrace_lane_serializer: RTL and testbench
===========================================

Name: memtrace_lane_serializer

Overview:
- Consumer end of the multi-lane memory-trace interface: accepts one per-lane request bundle at a time, issues the valid lanes in ascending lane order as individual requests on a single tagged memory port, and collects responses, which may return out of order.
- Returns a completed batch, carrying load data per lane, to the testbench side.
- Then re-asserts trace_read_ready.
- Tracks the trace-finished flag and raises all_done once the last batch drains.

Parameters:
- NUM_LANES, 4, lanes per trace bundle.
- DATA_WIDTH, 64, address/data width per lane.
- LOGSIZE_WIDTH, 8, log2(bytes) size field width per lane.
- TAG_WIDTH, max(1,$clog2(NUM_LANES)), memory tag width; the tag equals the lane id.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- trace_read_ready  out  1  block can accept a bundle
- trace_read_valid  in  NUM_LANES  per-lane request valid
- trace_read_address  in  DATA_WIDTH*NUM_LANES  lane g at [DATA_WIDTH*(g+1)-1:DATA_WIDTH*g]
- trace_read_is_store  in  NUM_LANES  per-lane store flag
- trace_read_size  in  LOGSIZE_WIDTH*NUM_LANES  per-lane log2 size, packed as address
- trace_read_data  in  DATA_WIDTH*NUM_LANES  per-lane store data
- trace_read_finished  in  1  trace exhausted
- mem_req_valid / mem_req_ready  out/in  1  request handshake
- mem_req_addr, mem_req_data  out  DATA_WIDTH  request fields
- mem_req_is_store  out  1  store flag
- mem_req_size  out  LOGSIZE_WIDTH  log2 size
- mem_req_tag  out  TAG_WIDTH  lane id
- mem_resp_valid  in  1  response valid
- mem_resp_ready  out  1  response accept
- mem_resp_tag  in  TAG_WIDTH  response lane id
- mem_resp_data  in  DATA_WIDTH  load data (ignored for stores)
- batch_done  out  1  one-cycle pulse: batch fully answered
- batch_mask  out  NUM_LANES  lanes in the completed batch
- batch_load_data  out  DATA_WIDTH*NUM_LANES  captured load data, packed as address
- all_done  out  1  sticky: finished seen and all batches drained
- err_spurious  out  1  sticky: response with a non-pending tag
- req_count  out  32  total requests issued, wraps at 2^32

Behaviour:
- Reset values: all outputs 0 except trace_read_ready=1. FSM enters IDLE; valid mask, pending mask, counters and flags are cleared.
- IDLE: trace_read_ready=1. Capture happens on a cycle with ready=1 and |trace_read_valid; all lane fields and the mask are registered and the FSM moves to ISSUE. A bundle with all valid bits 0 is not captured.
- trace_read_finished is latched whenever ready=1. If it arrives with an empty mask, the FSM goes to DONE in the next cycle. If it arrives with a valid bundle, the batch completes first and the FSM then goes to DONE.
- ISSUE: mem_req_valid=1 carries the lowest-indexed unissued lane. First request is presented in the cycle after capture. Fields stay stable while stalled (valid && !ready). On each handshake the lane's pending bit is set, the lane is marked issued, and req_count is incremented. When the last lane is issued the FSM moves to WAIT, or skips to COMPLETE if nothing is pending.
- Responses: mem_resp_ready=1 in ISSUE and WAIT, 0 otherwise. On resp handshake with pending[tag]=1:
  - pending[tag] is cleared.
  - For loads, data is stored into lane tag's slot.
- Spurious responses: a handshake with pending[tag]=0, or in IDLE/DONE, sets err_spurious and is otherwise ignored. A response for the same tag in the cycle of its own request handshake counts as spurious.
- Simultaneous request issue and response for different tags are both honoured in the same cycle.
- COMPLETE (one cycle): batch_done=1, with batch_mask and batch_load_data valid only this cycle; store-lane slots are 0. Next state is IDLE, or DONE if finished is latched.
- DONE: all_done=1 (sticky), trace_read_ready=0, mem_req_valid=0. DONE is left only by reset.
- Latency, all lanes ready and 1-cycle response: capture at N, requests N+1..N+k, last response >=N+k+1, batch_done the cycle after the last response, ready=1 the cycle after batch_done.
- Reset mid-operation: clears everything in the cycle after reset is sampled. In-flight memory transactions are abandoned, so the memory model must be reset with this block.

Decomposition:
- Package memtrace_pkg holds:
  - lane-field widths (DATA_WIDTH, LOGSIZE_WIDTH);
  - FSM state enum {IDLE, ISSUE, WAIT, COMPLETE, DONE};
  - packed-lane slice helper macros/functions.
- One sub-module, memtrace_lane_picker: combinational lowest-set-bit priority encoder over (mask & ~issued) giving index and any-flag.

Test Plan:
- Mask 4'b1011 with addresses 0x100,0x108,0x110,0x118, all loads, mem_req_ready=1, responses in order 1 cycle later -> tags 0,1,3 issued in order; batch_done with mask 1011 and the returned data in slots 0,1,3, slot 2 = 0; req_count=3.
- Same batch, responses returned in order 3,0,1 -> batch_done only after tag 1's response; data correctly placed by tag; err_spurious=0.
- mem_req_ready held 0 for 5 cycles during ISSUE -> request fields unchanged while stalled; no double issue; req_count advances only on handshakes.
- Response with tag 2 while pending=4'b0001 -> err_spurious=1, batch continues and completes normally.
- Bundle with mask 4'b0001 plus finished=1 in the same cycle -> batch completes, then all_done=1 and trace_read_ready stays 0.
- Reset asserted in WAIT with two lanes pending -> next cycle: ready=1, all_done=0, req_count=0, pending cleared.

Source files
------------

// File: rtl/memtrace_pkg.sv
// memtrace_pkg: shared definitions for the memory-trace lane serializer.
//   - Default lane-field widths (DATA_WIDTH, LOGSIZE_WIDTH).
//   - Serializer FSM state encoding.
//   - lane_lo(): bit offset of a lane inside a packed multi-lane bus.
package memtrace_pkg;

  localparam int unsigned DATA_WIDTH    = 64;
  localparam int unsigned LOGSIZE_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    COMPLETE,
    DONE
  } state_e;

  // Lane g of a packed bus occupies [width*(g+1)-1 : width*g].
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/memtrace_lane_picker.sv
// memtrace_lane_picker: combinational lowest-set-bit priority encoder.
// Ports:
//   i_mask  in   NUM_LANES  candidate lanes (valid & ~issued)
//   o_idx   out  TAG_WIDTH  index of the lowest set bit (0 when none)
//   o_any   out  1          at least one bit of i_mask is set
module memtrace_lane_picker #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned TAG_WIDTH = 2
) (
  input  logic [NUM_LANES-1:0] i_mask,
  output logic [TAG_WIDTH-1:0] o_idx,
  output logic                 o_any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = TAG_WIDTH'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memtrace_lane_serializer.sv
// memtrace_lane_serializer: consumer end of the multi-lane memory-trace interface.
// Captures one per-lane request bundle, issues its valid lanes in ascending lane order on a
// single tagged memory port (tag = lane id), gathers possibly out-of-order responses, then
// reports the finished batch with its load data. Once the trace-finished flag has been seen
// and the last batch has drained, all_done is raised and held until reset.
// Ports:
//   clock, reset                    clock; synchronous active-high reset
//   trace_read_*                    bundle input (ready/valid mask, packed lane fields, finished)
//   mem_req_*                       tagged request port (valid/ready handshake)
//   mem_resp_*                      tagged response port (valid/ready handshake)
//   batch_done/mask/load_data       one-cycle completion report
//   all_done                        sticky: finished seen and all batches drained
//   err_spurious                    sticky: response for a tag that was not pending
//   req_count                       total requests issued (wraps)
module memtrace_lane_serializer
  import memtrace_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned DATA_WIDTH    = memtrace_pkg::DATA_WIDTH,
  parameter int unsigned LOGSIZE_WIDTH = memtrace_pkg::LOGSIZE_WIDTH,
  parameter int unsigned TAG_WIDTH     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  output logic                            trace_read_ready,
  input  logic [NUM_LANES-1:0]            trace_read_valid,
  input  logic [DATA_WIDTH*NUM_LANES-1:0] trace_read_address,
  input  logic [NUM_LANES-1:0]            trace_read_is_store,
  input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] trace_read_size,
  input  logic [DATA_WIDTH*NUM_LANES-1:0] trace_read_data,
  input  logic                            trace_read_finished,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic [DATA_WIDTH-1:0]           mem_req_addr,
  output logic [DATA_WIDTH-1:0]           mem_req_data,
  output logic                            mem_req_is_store,
  output logic [LOGSIZE_WIDTH-1:0]        mem_req_size,
  output logic [TAG_WIDTH-1:0]            mem_req_tag,
  input  logic                            mem_resp_valid,
  output logic                            mem_resp_ready,
  input  logic [TAG_WIDTH-1:0]            mem_resp_tag,
  input  logic [DATA_WIDTH-1:0]           mem_resp_data,
  output logic                            batch_done,
  output logic [NUM_LANES-1:0]            batch_mask,
  output logic [DATA_WIDTH*NUM_LANES-1:0] batch_load_data,
  output logic                            all_done,
  output logic                            err_spurious,
  output logic [31:0]                     req_count
);

  state_e r_state, w_state_d;

  logic [NUM_LANES-1:0]     r_valid;
  logic [NUM_LANES-1:0]     r_issued;
  logic [NUM_LANES-1:0]     r_pending;
  logic [NUM_LANES-1:0]     r_is_store;
  logic [DATA_WIDTH-1:0]    r_addr  [NUM_LANES];
  logic [DATA_WIDTH-1:0]    r_wdata [NUM_LANES];
  logic [DATA_WIDTH-1:0]    r_ldata [NUM_LANES];
  logic [LOGSIZE_WIDTH-1:0] r_size  [NUM_LANES];
  logic                     r_finished;
  logic                     r_err;
  logic [31:0]              r_req_count;

  logic                 w_capture;
  logic [TAG_WIDTH-1:0] w_idx;
  logic                 w_any;
  logic                 w_req_fire;
  logic                 w_resp_fire;
  logic                 w_spurious;
  logic                 w_last_issue;
  logic [NUM_LANES-1:0] w_sel_bit;
  logic [NUM_LANES-1:0] w_resp_bit;
  logic [NUM_LANES-1:0] w_resp_clr;
  logic [NUM_LANES-1:0] w_pending_d;

  memtrace_lane_picker #(
    .NUM_LANES (NUM_LANES),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_picker (
    .i_mask (r_valid & ~r_issued),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign trace_read_ready = (r_state == IDLE);
  assign mem_req_valid    = (r_state == ISSUE) && w_any;
  assign mem_resp_ready   = (r_state == ISSUE) || (r_state == WAIT);
  assign batch_done       = (r_state == COMPLETE);
  assign all_done         = (r_state == DONE);
  assign err_spurious     = r_err;
  assign req_count        = r_req_count;

  assign w_capture   = trace_read_ready && (|trace_read_valid);
  assign w_req_fire  = mem_req_valid && mem_req_ready;
  assign w_resp_fire = mem_resp_valid && mem_resp_ready;

  // One-hot decodes of the lane being presented and of the response tag.
  always_comb begin
    w_sel_bit  = '0;
    w_resp_bit = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_sel_bit[i]  = mem_req_valid && (w_idx == TAG_WIDTH'(i));
      w_resp_bit[i] = (mem_resp_tag == TAG_WIDTH'(i));
    end
  end

  // Pending is tested on the registered value, so a response for the lane being issued in the
  // same cycle is not matched and is treated as spurious.
  assign w_resp_clr  = w_resp_fire ? (w_resp_bit & r_pending) : '0;
  assign w_pending_d = (r_pending | (w_req_fire ? w_sel_bit : '0)) & ~w_resp_clr;
  assign w_spurious  = (w_resp_fire && ((w_resp_bit & r_pending) == '0)) ||
                       (mem_resp_valid && ((r_state == IDLE) || (r_state == DONE)));
  assign w_last_issue = w_req_fire && ((r_valid & ~r_issued & ~w_sel_bit) == '0);

  // Request fields of the presented lane; zero when no request is offered.
  always_comb begin
    mem_req_addr     = '0;
    mem_req_data     = '0;
    mem_req_is_store = 1'b0;
    mem_req_size     = '0;
    mem_req_tag      = '0;
    if (mem_req_valid) begin
      mem_req_tag = w_idx;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_sel_bit[i]) begin
          mem_req_addr     = r_addr[i];
          mem_req_data     = r_wdata[i];
          mem_req_is_store = r_is_store[i];
          mem_req_size     = r_size[i];
        end
      end
    end
  end

  // Completion report is only driven during the COMPLETE cycle.
  always_comb begin
    batch_mask      = '0;
    batch_load_data = '0;
    if (r_state == COMPLETE) begin
      batch_mask = r_valid;
      for (int i = 0; i < NUM_LANES; i++) begin
        batch_load_data[lane_lo(unsigned'(i), DATA_WIDTH) +: DATA_WIDTH] = r_ldata[i];
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_capture) begin
          w_state_d = ISSUE;
        end else if (trace_read_finished || r_finished) begin
          w_state_d = DONE;
        end
      end
      ISSUE: begin
        if (w_last_issue || !w_any) begin
          w_state_d = (w_pending_d == '0) ? COMPLETE : WAIT;
        end
      end
      WAIT: begin
        if (w_pending_d == '0) begin
          w_state_d = COMPLETE;
        end
      end
      COMPLETE: w_state_d = r_finished ? DONE : IDLE;
      DONE:     w_state_d = DONE;
      default:  w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_issued    <= '0;
      r_pending   <= '0;
      r_is_store  <= '0;
      r_finished  <= 1'b0;
      r_err       <= 1'b0;
      r_req_count <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
        r_ldata[i] <= '0;
        r_size[i]  <= '0;
      end
    end else begin
      r_state   <= w_state_d;
      r_pending <= w_pending_d;

      if (trace_read_ready && trace_read_finished) begin
        r_finished <= 1'b1;
      end

      if (w_spurious) begin
        r_err <= 1'b1;
      end

      if (w_capture) begin
        r_valid    <= trace_read_valid;
        r_issued   <= '0;
        r_is_store <= trace_read_is_store;
        for (int i = 0; i < NUM_LANES; i++) begin
          r_addr[i]  <= trace_read_address[lane_lo(unsigned'(i), DATA_WIDTH) +: DATA_WIDTH];
          r_wdata[i] <= trace_read_data[lane_lo(unsigned'(i), DATA_WIDTH) +: DATA_WIDTH];
          r_size[i]  <= trace_read_size[lane_lo(unsigned'(i), LOGSIZE_WIDTH) +: LOGSIZE_WIDTH];
          r_ldata[i] <= '0;
        end
      end else if (w_req_fire) begin
        r_issued    <= r_issued | w_sel_bit;
        r_req_count <= r_req_count + 32'd1;
      end

      // Store lanes keep a zero slot; response data for them is dropped.
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_resp_clr[i] && !r_is_store[i]) begin
          r_ldata[i] <= mem_resp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_memtrace_lane_serializer.sv
// Directed self-checking bench for memtrace_lane_serializer (4 lanes, 64-bit data).
module tb_memtrace_lane_serializer;

  logic         clock = 1'b0;
  logic         reset;
  logic         trace_read_ready;
  logic [3:0]   trace_read_valid;
  logic [255:0] trace_read_address;
  logic [3:0]   trace_read_is_store;
  logic [31:0]  trace_read_size;
  logic [255:0] trace_read_data;
  logic         trace_read_finished;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [63:0]  mem_req_addr;
  logic [63:0]  mem_req_data;
  logic         mem_req_is_store;
  logic [7:0]   mem_req_size;
  logic [1:0]   mem_req_tag;
  logic         mem_resp_valid;
  logic         mem_resp_ready;
  logic [1:0]   mem_resp_tag;
  logic [63:0]  mem_resp_data;
  logic         batch_done;
  logic [3:0]   batch_mask;
  logic [255:0] batch_load_data;
  logic         all_done;
  logic         err_spurious;
  logic [31:0]  req_count;

  int n_tests = 0;
  int n_fail  = 0;

  memtrace_lane_serializer dut (
    .clock               (clock),
    .reset               (reset),
    .trace_read_ready    (trace_read_ready),
    .trace_read_valid    (trace_read_valid),
    .trace_read_address  (trace_read_address),
    .trace_read_is_store (trace_read_is_store),
    .trace_read_size     (trace_read_size),
    .trace_read_data     (trace_read_data),
    .trace_read_finished (trace_read_finished),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_addr        (mem_req_addr),
    .mem_req_data        (mem_req_data),
    .mem_req_is_store    (mem_req_is_store),
    .mem_req_size        (mem_req_size),
    .mem_req_tag         (mem_req_tag),
    .mem_resp_valid      (mem_resp_valid),
    .mem_resp_ready      (mem_resp_ready),
    .mem_resp_tag        (mem_resp_tag),
    .mem_resp_data       (mem_resp_data),
    .batch_done          (batch_done),
    .batch_mask          (batch_mask),
    .batch_load_data     (batch_load_data),
    .all_done            (all_done),
    .err_spurious        (err_spurious),
    .req_count           (req_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bundle(input logic [3:0] m, input logic [3:0] st, input logic [63:0] base,
                        input logic fin);
    trace_read_valid    = m;
    trace_read_is_store = st;
    trace_read_finished = fin;
    for (int g = 0; g < 4; g++) begin
      trace_read_address[g*64 +: 64] = base + 64'(8 * g);
      trace_read_data[g*64 +: 64]    = 64'hA000 + 64'(g);
      trace_read_size[g*8 +: 8]      = 8'd3;
    end
  endtask

  task automatic clear_bundle();
    trace_read_valid    = '0;
    trace_read_finished = 1'b0;
  endtask

  task automatic resp(input logic v, input logic [1:0] t, input logic [63:0] d);
    mem_resp_valid = v;
    mem_resp_tag   = t;
    mem_resp_data  = d;
  endtask

  function automatic logic [255:0] pack4(input logic [63:0] d3, input logic [63:0] d2,
                                         input logic [63:0] d1, input logic [63:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  initial begin
    reset               = 1'b1;
    trace_read_valid    = '0;
    trace_read_address  = '0;
    trace_read_is_store = '0;
    trace_read_size     = '0;
    trace_read_data     = '0;
    trace_read_finished = 1'b0;
    mem_req_ready       = 1'b1;
    resp(1'b0, 2'd0, 64'd0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_ready", trace_read_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_resp_ready", mem_resp_ready, 0);
    chk("rst_batch_done", batch_done, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_req_count", req_count, 0);

    // Empty mask is not captured
    tick();
    chk("empty_ready", trace_read_ready, 1);
    chk("empty_req_valid", mem_req_valid, 0);

    // T1: mask 1011, in-order responses one cycle after each request
    bundle(4'b1011, 4'b0000, 64'h100, 1'b0);
    tick();
    clear_bundle();
    chk("t1_ready_low", trace_read_ready, 0);
    chk("t1_req0_valid", mem_req_valid, 1);
    chk("t1_req0_addr", mem_req_addr, 64'h100);
    chk("t1_req0_tag", mem_req_tag, 0);
    chk("t1_req0_size", mem_req_size, 3);
    tick();
    chk("t1_req1_tag", mem_req_tag, 1);
    chk("t1_req1_addr", mem_req_addr, 64'h108);
    resp(1'b1, 2'd0, 64'h1111_0000);
    tick();
    chk("t1_req3_tag", mem_req_tag, 3);
    chk("t1_req3_addr", mem_req_addr, 64'h118);
    resp(1'b1, 2'd1, 64'h2222);
    tick();
    chk("t1_wait_req_valid", mem_req_valid, 0);
    chk("t1_wait_resp_ready", mem_resp_ready, 1);
    chk("t1_req_count", req_count, 3);
    resp(1'b1, 2'd3, 64'h3333);
    tick();
    resp(1'b0, 2'd0, 64'd0);
    chk("t1_batch_done", batch_done, 1);
    chk("t1_batch_mask", batch_mask, 4'b1011);
    chk("t1_load_data", batch_load_data, pack4(64'h3333, 64'h0, 64'h2222, 64'h1111_0000));
    tick();
    chk("t1_done_pulse", batch_done, 0);
    chk("t1_ready_back", trace_read_ready, 1);

    // T2: same batch, responses 3,0,1
    bundle(4'b1011, 4'b0000, 64'h100, 1'b0);
    tick();
    clear_bundle();
    tick();
    tick();
    tick();
    resp(1'b1, 2'd3, 64'hC3);
    chk("t2_not_done_a", batch_done, 0);
    tick();
    resp(1'b1, 2'd0, 64'hC0);
    chk("t2_not_done_b", batch_done, 0);
    tick();
    resp(1'b1, 2'd1, 64'hC1);
    chk("t2_not_done_c", batch_done, 0);
    tick();
    resp(1'b0, 2'd0, 64'd0);
    chk("t2_batch_done", batch_done, 1);
    chk("t2_load_data", batch_load_data, pack4(64'hC3, 64'h0, 64'hC1, 64'hC0));
    chk("t2_err", err_spurious, 0);
    chk("t2_req_count", req_count, 6);
    tick();

    // T3: request stalled for 5 cycles; lane 1 is a store
    mem_req_ready = 1'b0;
    bundle(4'b0110, 4'b0010, 64'h200, 1'b0);
    tick();
    clear_bundle();
    chk("t3_store_flag", mem_req_is_store, 1);
    chk("t3_store_data", mem_req_data, 64'hA001);
    for (int i = 0; i < 5; i++) begin
      chk("t3_stall_addr", mem_req_addr, 64'h208);
      chk("t3_stall_tag", mem_req_tag, 1);
      chk("t3_stall_count", req_count, 6);
      tick();
    end
    chk("t3_still_valid", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    tick();
    chk("t3_req2_tag", mem_req_tag, 2);
    chk("t3_req2_addr", mem_req_addr, 64'h210);
    chk("t3_req2_load", mem_req_is_store, 0);
    chk("t3_count_7", req_count, 7);
    resp(1'b1, 2'd1, 64'hDEAD);
    tick();
    chk("t3_wait_req_valid", mem_req_valid, 0);
    chk("t3_count_8", req_count, 8);
    resp(1'b1, 2'd2, 64'h5555);
    tick();
    resp(1'b0, 2'd0, 64'd0);
    chk("t3_batch_done", batch_done, 1);
    chk("t3_batch_mask", batch_mask, 4'b0110);
    chk("t3_load_data", batch_load_data, pack4(64'h0, 64'h5555, 64'h0, 64'h0));
    tick();

    // T4: spurious tag 2 while only lane 0 pending
    bundle(4'b0001, 4'b0000, 64'h300, 1'b0);
    tick();
    clear_bundle();
    tick();
    resp(1'b1, 2'd2, 64'hBAD);
    chk("t4_err_before", err_spurious, 0);
    tick();
    chk("t4_err_set", err_spurious, 1);
    chk("t4_not_done", batch_done, 0);
    chk("t4_resp_ready", mem_resp_ready, 1);
    resp(1'b1, 2'd0, 64'h1234);
    tick();
    resp(1'b0, 2'd0, 64'd0);
    chk("t4_batch_done", batch_done, 1);
    chk("t4_batch_mask", batch_mask, 4'b0001);
    chk("t4_load_data", batch_load_data, pack4(64'h0, 64'h0, 64'h0, 64'h1234));
    chk("t4_req_count", req_count, 9);
    chk("t4_err_sticky", err_spurious, 1);
    tick();

    // T5: mask 0001 with finished in the same cycle
    bundle(4'b0001, 4'b0000, 64'h400, 1'b1);
    tick();
    clear_bundle();
    chk("t5_ready_low", trace_read_ready, 0);
    chk("t5_req_valid", mem_req_valid, 1);
    chk("t5_all_done_early", all_done, 0);
    tick();
    resp(1'b1, 2'd0, 64'h77);
    tick();
    resp(1'b0, 2'd0, 64'd0);
    chk("t5_batch_done", batch_done, 1);
    chk("t5_all_done_not_yet", all_done, 0);
    tick();
    chk("t5_all_done", all_done, 1);
    chk("t5_ready_stays_low", trace_read_ready, 0);
    chk("t5_req_idle", mem_req_valid, 0);
    chk("t5_req_count", req_count, 10);
    tick();
    chk("t5_all_done_sticky", all_done, 1);
    chk("t5_ready_still_low", trace_read_ready, 0);

    // T6: reset in WAIT with two lanes pending
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_ready", trace_read_ready, 1);
    chk("t6_err_clear", err_spurious, 0);
    bundle(4'b0011, 4'b0000, 64'h500, 1'b0);
    tick();
    clear_bundle();
    tick();
    tick();
    chk("t6_wait_resp_ready", mem_resp_ready, 1);
    chk("t6_wait_count", req_count, 2);
    reset = 1'b1;
    tick();
    chk("t6_rst_ready", trace_read_ready, 1);
    chk("t6_rst_all_done", all_done, 0);
    chk("t6_rst_count", req_count, 0);
    chk("t6_rst_resp_ready", mem_resp_ready, 0);
    reset = 1'b0;
    // Lane 1 was pending before reset; answering it now must be flagged
    bundle(4'b0001, 4'b0000, 64'h600, 1'b0);
    tick();
    clear_bundle();
    tick();
    resp(1'b1, 2'd1, 64'h99);
    tick();
    chk("t6_pending_cleared", err_spurious, 1);
    chk("t6_not_done", batch_done, 0);
    resp(1'b1, 2'd0, 64'h66);
    tick();
    resp(1'b0, 2'd0, 64'd0);
    chk("t6_batch_done", batch_done, 1);
    chk("t6_load_data", batch_load_data, pack4(64'h0, 64'h0, 64'h0, 64'h66));
    chk("t6_req_count", req_count, 1);
    tick();

    // T7: finished with an empty mask goes straight to DONE
    trace_read_finished = 1'b1;
    tick();
    trace_read_finished = 1'b0;
    chk("t7_all_done", all_done, 1);
    chk("t7_ready_low", trace_read_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
